// File: rtl/memkkk.sv
// memkkk: DEPTH x DATA_W register-file memory with asynchronous read,
// synchronous write and synchronous active-high clear of every word.
//
// Ports:
//   clk     in   1       single clock, all state changes on rising edge
//   rst     in   1       synchronous active-high reset, clears all words
//   address in   32      word address; only the low IDX_W bits select a word
//   dataIn  in   DATA_W  write data
//   wEn     in   1       write enable, active-high
//   memOut  out  DATA_W  contents of the word selected by address
module memkkk #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              wEn,
    output logic [DATA_W-1:0] memOut
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [IDX_W-1:0]  w_idx;
    logic              w_unused_addr;

    // Upper address bits are dropped, so addresses wrap modulo DEPTH.
    assign w_idx         = address[IDX_W-1:0];
    assign w_unused_addr = ^address[31:IDX_W];

    // Reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wEn) begin
            r_mem[w_idx] <= dataIn;
        end
    end

    // Read path is purely combinational from the stored word; there is
    // no forwarding of dataIn, so a same-address write shows after the edge.
    assign memOut = r_mem[w_idx];

endmodule

// File: tb/tb_memkkk.sv
// tb_memkkk: directed self-checking bench for memkkk.
// Inputs change 1 time unit after each rising edge; checks sample mid-cycle.
module tb_memkkk;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic        wEn;
    logic [31:0] memOut;

    int total;
    int bad;

    memkkk #(
        .DATA_W(32),
        .DEPTH (32),
        .IDX_W (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .address(address),
        .dataIn (dataIn),
        .wEn    (wEn),
        .memOut (memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge; return 1 unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] model [32];
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wEn     = 1'b0;
        address = 32'd0;
        dataIn  = 32'd0;
        #1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Reset state.
        address = 32'd0;  #1 chk("rst_a0", memOut, 32'd0);
        address = 32'd31; #1 chk("rst_a31", memOut, 32'd0);

        // Full sweep write then read back.
        wEn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address = i;
            dataIn  = i;
            step();
        end
        wEn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            address = i;
            #4 chk($sformatf("sweep_%0d", i), memOut, i);
            step();
        end

        // Asynchronous read between edges.
        address = 32'd5; #1 chk("async_5", memOut, 32'd5);
        address = 32'd9; #1 chk("async_9", memOut, 32'd9);

        // rst rising between edges has no effect yet.
        rst = 1'b1;
        #1 chk("rst_no_async", memOut, 32'd9);

        // Reset edge with a competing write to word 3.
        wEn     = 1'b1;
        address = 32'd3;
        dataIn  = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        wEn = 1'b0;
        #1 chk("rst_blocks_w3", memOut, 32'd0);
        address = 32'd0;  #1 chk("rst_clr_0", memOut, 32'd0);
        address = 32'd17; #1 chk("rst_clr_17", memOut, 32'd0);
        address = 32'd31; #1 chk("rst_clr_31", memOut, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Write-disable holds the stored word.
        address = 32'd7;
        dataIn  = 32'hA5A5_A5A5;
        wEn     = 1'b1;
        step();
        model[7] = 32'hA5A5_A5A5;
        wEn    = 1'b0;
        dataIn = 32'h1234_5678;
        step();
        step();
        step();
        chk("wdis_7", memOut, 32'hA5A5_A5A5);

        // Mid-cycle wEn pulse that is gone by the edge writes nothing.
        address = 32'd10;
        dataIn  = 32'h5555_5555;
        wEn     = 1'b1;
        #2 wEn  = 1'b0;
        step();
        chk("glitch_10", memOut, 32'd0);

        // Wrap-around: address 34 selects word 2.
        address = 32'd34;
        dataIn  = 32'hDEAD_BEEF;
        wEn     = 1'b1;
        step();
        wEn = 1'b0;
        model[2] = 32'hDEAD_BEEF;
        address = 32'd2;
        #1 chk("wrap_2", memOut, 32'hDEAD_BEEF);
        for (int i = 0; i < 32; i++) begin
            address = i;
            #1 chk($sformatf("wrap_keep_%0d", i), memOut, model[i]);
        end

        // Read-during-write: old value before the edge, new after.
        address = 32'd4;
        dataIn  = 32'h11;
        wEn     = 1'b1;
        step();
        dataIn = 32'h22;
        #1 chk("rdw_before", memOut, 32'h11);
        step();
        wEn = 1'b0;
        chk("rdw_after", memOut, 32'h22);

        // Reset in the middle of a write sequence clears older words too.
        wEn     = 1'b1;
        address = 32'd20;
        dataIn  = 32'hCAFE_0001;
        step();
        address = 32'd21;
        dataIn  = 32'hCAFE_0002;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        wEn = 1'b0;
        address = 32'd20; #1 chk("midrst_20", memOut, 32'd0);
        address = 32'd21; #1 chk("midrst_21", memOut, 32'd0);
        address = 32'd2;  #1 chk("midrst_2", memOut, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
